// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: PC, prefetch queue, redirect flush, self-halt on HLT.
// Optional performance counters are enabled with `define FETCH_SEQUENCER_PERF_EN.
module fetch_sequencer #(
  parameter int          DEPTH    = 2,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  output logic [15:0] instr_out,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        halted
`ifdef FETCH_SEQUENCER_PERF_EN
  ,
  output logic [15:0] perf_fetches,
  output logic [15:0] perf_stalls
`endif
);

  localparam int          AW     = $clog2(DEPTH);
  localparam logic [AW:0] FULL   = (AW+1)'(DEPTH);
  localparam logic [3:0]  HLT_OP = 4'b1110;

  typedef enum logic {RUN, STOPPED} state_t;

  state_t        state, state_d;
  logic [15:0]   fetch_pc;
  logic [15:0]   qdata [DEPTH];
  logic [15:0]   qpc   [DEPTH];
  logic [AW-1:0] head, tail;
  logic [AW:0]   count;
  logic          pop, push;

  assign imem_addr   = fetch_pc;
  assign instr_valid = (count != '0);
  assign instr_out   = qdata[head];
  assign instr_pc    = qpc[head];
  assign halted      = (state == STOPPED) && (count == '0);

  always_comb begin
    pop     = instr_valid && instr_ready;
    push    = 1'b0;
    state_d = state;
    if (redirect) begin
      state_d = RUN;
    end else if (state == RUN && (count < FULL || pop)) begin
      push = 1'b1;
      if (imem_data[15:12] == HLT_OP) state_d = STOPPED;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      fetch_pc <= RESET_PC;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
    end else begin
      state <= state_d;
      if (redirect) begin
        // Flush: pointers rewind together, any same-cycle pop is already consumed.
        fetch_pc <= redirect_pc;
        count    <= '0;
        head     <= '0;
        tail     <= '0;
      end else begin
        if (push) begin
          fetch_pc <= fetch_pc + 16'd1;
          tail     <= tail + 1'b1;
        end
        if (pop) head <= head + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // Queue storage needs no reset; count gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      qdata[tail] <= imem_data;
      qpc[tail]   <= fetch_pc;
    end
  end

`ifdef FETCH_SEQUENCER_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetches <= '0;
      perf_stalls  <= '0;
    end else begin
      if (push && perf_fetches != '1) perf_fetches <= perf_fetches + 16'd1;
      if (state == RUN && count == FULL && !pop && perf_stalls != '1)
        perf_stalls <= perf_stalls + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer with a behavioural 256x16 async ROM.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] imem_addr, imem_data, instr_out, instr_pc, redirect_pc;
  logic        instr_valid, instr_ready, redirect, halted;
`ifdef FETCH_SEQUENCER_PERF_EN
  logic [15:0] perf_fetches, perf_stalls;
`endif
  logic [15:0] rom [256];
  int          total = 0;
  int          bad   = 0;

  fetch_sequencer #(.DEPTH(2), .RESET_PC(16'h0000)) dut (
    .clk          (clk),
    .reset        (reset),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .instr_out    (instr_out),
    .instr_pc     (instr_pc),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .halted       (halted)
`ifdef FETCH_SEQUENCER_PERF_EN
    ,
    .perf_fetches (perf_fetches),
    .perf_stalls  (perf_stalls)
`endif
  );

  always #5 clk = ~clk;
  assign imem_data = rom[imem_addr[7:0]];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int unsigned i = 0; i < 256; i++) rom[i] = 16'h3000 | 16'(i);
    rom[0] = 16'h1105; rom[1] = 16'h1203; rom[2] = 16'h2312; rom[3] = 16'h4431;
    rom[4] = 16'h5340; rom[5] = 16'h1001; rom[6] = 16'h2000; rom[7] = 16'hE000;

    reset = 1'b1; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    step(); step();
    check("rst_valid", 16'(instr_valid), 16'd0);
    check("rst_halted", 16'(halted), 16'd0);
    check("rst_addr", imem_addr, 16'h0000);

    // Sample program streams straight through to HLT
    instr_ready = 1'b1; reset = 1'b0;
    step();
    check("first_valid", 16'(instr_valid), 16'd1);
    check("first_pc", instr_pc, 16'h0000);
    check("first_out", instr_out, 16'h1105);
    for (int k = 1; k < 8; k++) begin
      step();
      check("stream_pc", instr_pc, 16'(k));
      check("stream_valid", 16'(instr_valid), 16'd1);
    end
    check("hlt_out", instr_out, 16'hE000);
    check("hlt_halted_early", 16'(halted), 16'd0);
    check("hlt_fetch_pc", imem_addr, 16'h0008);
    step();
    check("drained_valid", 16'(instr_valid), 16'd0);
    check("halted_rise", 16'(halted), 16'd1);
    step(); step();
    check("stopped_addr", imem_addr, 16'h0008);
    check("stopped_halted", 16'(halted), 16'd1);

    // Redirect leaves STOPPED; imem_addr must not follow redirect combinationally
    redirect = 1'b1; redirect_pc = 16'h0020;
    #1;
    check("no_comb_redirect", imem_addr, 16'h0008);
    step();
    check("halted_fall", 16'(halted), 16'd0);
    check("redir_addr", imem_addr, 16'h0020);
    redirect = 1'b0;

    // Backpressure after reset: queue fills at 2, then drains bubble-free
    reset = 1'b1; instr_ready = 1'b0;
    step();
    reset = 1'b0;
    for (int k = 0; k < 5; k++) step();
    check("bp_valid", 16'(instr_valid), 16'd1);
    check("bp_addr", imem_addr, 16'h0002);
    check("bp_head", instr_pc, 16'h0000);
    instr_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      step();
      check("bp_stream_pc", instr_pc, 16'(k));
    end

    // Redirect with a full queue
    redirect = 1'b1; redirect_pc = 16'h0040; instr_ready = 1'b0;
    step();
    check("flush_valid", 16'(instr_valid), 16'd0);
    check("flush_addr", imem_addr, 16'h0040);
    redirect = 1'b0;
    step();
    check("tgt_valid", 16'(instr_valid), 16'd1);
    check("tgt_pc", instr_pc, 16'h0040);
    check("tgt_out", instr_out, 16'h3040);

    // Redirect coinciding with pop and would-be push
    instr_ready = 1'b1;
    step();
    check("pre_redir_pc", instr_pc, 16'h0041);
    redirect = 1'b1; redirect_pc = 16'h0080;
    step();
    check("popredir_valid", 16'(instr_valid), 16'd0);
    redirect = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("new_stream_pc", instr_pc, 16'h0080 + 16'(k));
    end

    // PC wrap at 16'hFFFF
    redirect = 1'b1; redirect_pc = 16'hFFFF;
    step();
    check("wrap_flush", 16'(instr_valid), 16'd0);
    check("wrap_addr", imem_addr, 16'hFFFF);
    redirect = 1'b0;
    step();
    check("wrap_pc_ffff", instr_pc, 16'hFFFF);
    check("wrap_out_ff", instr_out, 16'h30FF);
    step();
    check("wrap_pc_0000", instr_pc, 16'h0000);
    check("wrap_out_00", instr_out, 16'h1105);

    // Reset with a full queue
    instr_ready = 1'b0;
    step(); step();
    check("full_valid", 16'(instr_valid), 16'd1);
    check("full_hold_addr", imem_addr, 16'h0002);
    reset = 1'b1;
    step();
    check("midrst_valid", 16'(instr_valid), 16'd0);
    check("midrst_addr", imem_addr, 16'h0000);
    check("midrst_halted", 16'(halted), 16'd0);
`ifdef FETCH_SEQUENCER_PERF_EN
    check("midrst_fetches", perf_fetches, 16'h0000);
    check("midrst_stalls", perf_stalls, 16'h0000);
`endif
    reset = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
